// File: rtl/sprite_fetch_arbiter.sv
// sprite_fetch_arbiter: per-pixel sprite arbitration and pixel-memory fetch, latency MEM_LAT+3; colour keying under SPRITE_FETCH_TRANSPARENCY_EN
module sprite_fetch_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 19
`ifdef SPRITE_FETCH_TRANSPARENCY_EN
    ,
    parameter logic [23:0] KEY_COLOR = 24'hFF00FF
`endif
) (
    input  logic              VGA_CLK,
    input  logic              RESET,
    input  logic [7:0]        SPRITES_EN,
    input  logic [10:0]       X,
    input  logic [10:0]       Y,
    input  logic              FRAME_START,
    input  logic              CFG_WE,
    input  logic [2:0]        CFG_IDX,
    input  logic [ADDR_W-1:0] CFG_BASE,
    input  logic [8:0]        CFG_W,
    input  logic [8:0]        CFG_X0,
    input  logic [8:0]        CFG_Y0,
    output logic              MEM_RD,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [23:0]       MEM_DATA,
    output logic [23:0]       RGB,
    output logic              RGB_VALID,
    output logic [2:0]        SEL_IDX
);
    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [8:0]        w;
        logic [8:0]        x0;
        logic [8:0]        y0;
    } ent_t;

    ent_t [7:0]              shd_q, shd_d, act_q, act_d;
    logic                    s1_vld_q, s1_vld_d;
    logic [2:0]              s1_idx_q, s1_idx_d;
    logic [8:0]              s1_lx_q, s1_lx_d, s1_ly_q, s1_ly_d, s1_w_q, s1_w_d;
    logic [ADDR_W-1:0]       s1_base_q, s1_base_d;
    logic                    rd_q, rd_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [2:0]              s2_idx_q, s2_idx_d;
    logic [MEM_LAT-1:0]      sh_vld_q, sh_vld_d;
    logic [MEM_LAT-1:0][2:0] sh_idx_q, sh_idx_d;
    logic [23:0]             rgb_q, rgb_d;
    logic                    vld_q, vld_d;
    logic [2:0]              sel_q, sel_d;
    logic [2:0]              win;
    logic                    unused_xy;
`ifdef SPRITE_FETCH_TRANSPARENCY_EN
    logic [23:0]             bg_q, bg_d;
    logic                    key;
`endif

    // Sprites live in a 512x512 space, so only the low coordinate bits matter
    assign unused_xy = ^{X[10:9], Y[10:9]};

    always_comb begin
        win = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (SPRITES_EN[i]) win = 3'(i);
    end

    always_comb begin
        shd_d = shd_q;
        if (CFG_WE) shd_d[CFG_IDX] = '{base: CFG_BASE, w: CFG_W, x0: CFG_X0, y0: CFG_Y0};
        act_d = FRAME_START ? shd_q : act_q;
        s1_vld_d = |SPRITES_EN;
        s1_idx_d = win;
        s1_lx_d = X[8:0] - act_q[win].x0;
        s1_ly_d = Y[8:0] - act_q[win].y0;
        // Base and width travel with the pixel so a commit mid-flight cannot split its lookup
        s1_base_d = act_q[win].base;
        s1_w_d = act_q[win].w;
        rd_d = s1_vld_q;
        addr_d = s1_vld_q ? s1_base_q + ADDR_W'(s1_ly_q) * ADDR_W'(s1_w_q) + ADDR_W'(s1_lx_q) : addr_q;
        s2_idx_d = s1_idx_q;
        sh_vld_d = sh_vld_q;
        sh_idx_d = sh_idx_q;
        sh_vld_d[0] = rd_q;
        sh_idx_d[0] = s2_idx_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            sh_vld_d[i] = sh_vld_q[i-1];
            sh_idx_d[i] = sh_idx_q[i-1];
        end
        vld_d = sh_vld_q[MEM_LAT-1];
`ifdef SPRITE_FETCH_TRANSPARENCY_EN
        key = MEM_DATA == KEY_COLOR;
        rgb_d = !sh_vld_q[MEM_LAT-1] ? 24'h0 : key ? bg_q : MEM_DATA;
        sel_d = !sh_vld_q[MEM_LAT-1] ? sel_q : key ? 3'd7 : sh_idx_q[MEM_LAT-1];
        bg_d = sh_vld_q[MEM_LAT-1] && !key && sh_idx_q[MEM_LAT-1] == 3'd7 ? MEM_DATA : bg_q;
`else
        rgb_d = sh_vld_q[MEM_LAT-1] ? MEM_DATA : 24'h0;
        sel_d = sh_vld_q[MEM_LAT-1] ? sh_idx_q[MEM_LAT-1] : sel_q;
`endif
    end

    always_ff @(posedge VGA_CLK) begin
        if (RESET) begin
            shd_q <= '0;
            act_q <= '0;
            s1_vld_q <= 1'b0;
            s1_idx_q <= '0;
            s1_lx_q <= '0;
            s1_ly_q <= '0;
            s1_w_q <= '0;
            s1_base_q <= '0;
            rd_q <= 1'b0;
            addr_q <= '0;
            s2_idx_q <= '0;
            sh_vld_q <= '0;
            sh_idx_q <= '0;
            rgb_q <= '0;
            vld_q <= 1'b0;
            sel_q <= '0;
`ifdef SPRITE_FETCH_TRANSPARENCY_EN
            bg_q <= '0;
`endif
        end else begin
            shd_q <= shd_d;
            act_q <= act_d;
            s1_vld_q <= s1_vld_d;
            s1_idx_q <= s1_idx_d;
            s1_lx_q <= s1_lx_d;
            s1_ly_q <= s1_ly_d;
            s1_w_q <= s1_w_d;
            s1_base_q <= s1_base_d;
            rd_q <= rd_d;
            addr_q <= addr_d;
            s2_idx_q <= s2_idx_d;
            sh_vld_q <= sh_vld_d;
            sh_idx_q <= sh_idx_d;
            rgb_q <= rgb_d;
            vld_q <= vld_d;
            sel_q <= sel_d;
`ifdef SPRITE_FETCH_TRANSPARENCY_EN
            bg_q <= bg_d;
`endif
        end
    end

    assign MEM_RD = rd_q;
    assign MEM_ADDR = addr_q;
    assign RGB = rgb_q;
    assign RGB_VALID = vld_q;
    assign SEL_IDX = sel_q;
endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// tb_sprite_fetch_arbiter: randomized scoreboard bench for sprite_fetch_arbiter with a behavioural table/arbitration model
module tb_sprite_fetch_arbiter;
    localparam int L = 2;
    localparam int AW = 19;
    localparam int KEY = 24'hFF00FF;

    logic          VGA_CLK = 1'b0;
    logic          RESET = 1'b1;
    logic [7:0]    SPRITES_EN = '0;
    logic [10:0]   X = 11'h7FF, Y = 11'h7FF;
    logic          FRAME_START = 1'b0, CFG_WE = 1'b0;
    logic [2:0]    CFG_IDX = '0;
    logic [AW-1:0] CFG_BASE = '0;
    logic [8:0]    CFG_W = '0, CFG_X0 = '0, CFG_Y0 = '0;
    logic          MEM_RD;
    logic [AW-1:0] MEM_ADDR;
    logic [23:0]   MEM_DATA = '0;
    logic [23:0]   RGB;
    logic          RGB_VALID;
    logic [2:0]    SEL_IDX;

    sprite_fetch_arbiter #(.MEM_LAT(L), .ADDR_W(AW)) dut (
        .VGA_CLK(VGA_CLK), .RESET(RESET), .SPRITES_EN(SPRITES_EN), .X(X), .Y(Y),
        .FRAME_START(FRAME_START), .CFG_WE(CFG_WE), .CFG_IDX(CFG_IDX), .CFG_BASE(CFG_BASE),
        .CFG_W(CFG_W), .CFG_X0(CFG_X0), .CFG_Y0(CFG_Y0), .MEM_RD(MEM_RD), .MEM_ADDR(MEM_ADDR),
        .MEM_DATA(MEM_DATA), .RGB(RGB), .RGB_VALID(RGB_VALID), .SEL_IDX(SEL_IDX)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    int cyc = 0;
    always @(posedge VGA_CLK) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    typedef struct {int addr; int cyc;} rd_t;
    typedef struct {int rgb; int idx; int cyc;} px_t;
    rd_t aq[$];
    px_t oq[$];
    int hq[$];
    int sh_base[8], sh_w[8], sh_x0[8], sh_y0[8];
    int ac_base[8], ac_w[8], ac_x0[8], ac_y0[8];
    int bg = 0;
    bit p_we = 0;
    int p_idx, p_base, p_w, p_x0, p_y0;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, got, exp, cyc);
        end
    endtask

    function automatic int word(input int a);
        int v;
        if (a == 725) return 24'h123456;
        if (a == 726) return 24'h00FF00;
        if (a == 100000) return KEY;
        v = ((a * 40503) ^ (a >> 3) ^ 24'h5A5A5A) & 24'hFFFFFF;
        return v == KEY ? 24'hFF00FE : v;
    endfunction

    always @(negedge VGA_CLK) begin : mem
        int a;
        hq.push_back(MEM_RD ? int'(MEM_ADDR) : -1);
        if (hq.size() > L) begin
            a = hq.pop_front();
            MEM_DATA = a < 0 ? 24'($urandom) : 24'(word(a));
        end
    end

    always @(negedge VGA_CLK) begin : mon
        rd_t r;
        px_t p;
        if (MEM_RD) begin
            if (aq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_rd: MEM_RD=1 addr=%0d with no read expected (cycle %0d)", MEM_ADDR, cyc);
            end else begin
                r = aq.pop_front();
                chk("mem_addr", 32'(MEM_ADDR), 32'(r.addr));
                chk("rd_cycle", 32'(cyc), 32'(r.cyc));
            end
        end
        if (RGB_VALID) begin
            if (oq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_rgb: RGB_VALID=1 rgb=%0h with no pixel expected (cycle %0d)", RGB, cyc);
            end else begin
                p = oq.pop_front();
                chk("rgb", 32'(RGB), 32'(p.rgb));
                chk("sel_idx", 32'(SEL_IDX), 32'(p.idx));
                chk("rgb_cycle", 32'(cyc), 32'(p.cyc));
            end
        end
    end

    task automatic set_cfg(input int i, b, w, x0, y0);
        p_we = 1; p_idx = i; p_base = b; p_w = w; p_x0 = x0; p_y0 = y0;
    endtask

    task automatic step(input logic [7:0] en, input int x, y, input bit fs);
        int k, lx, ly, ad, d, r, s;
        SPRITES_EN = en; X = 11'(x); Y = 11'(y); FRAME_START = fs;
        CFG_WE = p_we; CFG_IDX = 3'(p_idx); CFG_BASE = AW'(p_base);
        CFG_W = 9'(p_w); CFG_X0 = 9'(p_x0); CFG_Y0 = 9'(p_y0);
        if (en != 0) begin
            k = 0;
            while (!en[k]) k++;
            lx = ((x % 512) - ac_x0[k] + 512) % 512;
            ly = ((y % 512) - ac_y0[k] + 512) % 512;
            ad = (ac_base[k] + ly * ac_w[k] + lx) % (1 << AW);
            d = word(ad); r = d; s = k;
`ifdef SPRITE_FETCH_TRANSPARENCY_EN
            if (d == KEY) begin r = bg; s = 7; end
            else if (k == 7) bg = d;
`endif
            aq.push_back('{ad, cyc + 2});
            oq.push_back('{r, s, cyc + 3 + L});
        end
        if (fs) begin
            ac_base = sh_base; ac_w = sh_w; ac_x0 = sh_x0; ac_y0 = sh_y0;
        end
        if (p_we) begin
            sh_base[p_idx] = p_base % (1 << AW); sh_w[p_idx] = p_w % 512;
            sh_x0[p_idx] = p_x0 % 512; sh_y0[p_idx] = p_y0 % 512;
        end
        p_we = 0;
        @(negedge VGA_CLK);
    endtask

    task automatic idle(input int n);
        repeat (n) step(8'h00, 2047, 2047, 0);
    endtask

    task automatic do_reset(input int n);
        RESET = 1'b1;
        idle(n);
        aq.delete(); oq.delete();
        for (int i = 0; i < 8; i++) begin
            sh_base[i] = 0; sh_w[i] = 0; sh_x0[i] = 0; sh_y0[i] = 0;
            ac_base[i] = 0; ac_w[i] = 0; ac_x0[i] = 0; ac_y0[i] = 0;
        end
        bg = 0;
        RESET = 1'b0;
    endtask

    task automatic chk_reset_state();
        chk("rst_mem_rd", 32'(MEM_RD), 0);
        chk("rst_mem_addr", 32'(MEM_ADDR), 0);
        chk("rst_rgb", 32'(RGB), 0);
        chk("rst_rgb_valid", 32'(RGB_VALID), 0);
        chk("rst_sel_idx", 32'(SEL_IDX), 0);
    endtask

    initial begin
        @(negedge VGA_CLK);
        do_reset(3);
        chk_reset_state();
        for (int i = 0; i < 20; i++) begin
            step(8'h00, 2047, 2047, 0);
            chk("idle", 32'({MEM_RD, RGB_VALID, RGB}), 0);
        end
        set_cfg(7, 0, 360, 0, 0);
        step(8'h00, 2047, 2047, 0);
        step(8'h00, 2047, 2047, 1);
        step(8'h80, 5, 2, 0);
        idle(1);
        chk("addr_725", 32'(MEM_ADDR), 725);
        chk("rd_725", 32'(MEM_RD), 1);
        idle(L + 1);
        chk("rgb_123456", 32'(RGB), 24'h123456);
        chk("valid_123456", 32'(RGB_VALID), 1);
        chk("sel_7", 32'(SEL_IDX), 7);
        set_cfg(6, 20000, 168, 192, 193);
        step(8'h00, 2047, 2047, 0);
        set_cfg(0, 100000, 16, 0, 0);
        step(8'h00, 2047, 2047, 1);
        step(8'hC0, 200, 195, 0);
        step(8'h00, 2047, 2047, 1);
        chk("addr_20344", 32'(MEM_ADDR), 20344);
        for (int i = 0; i < 12; i++) step(8'hC1, i, 3, 0);
        idle(L + 4);
        set_cfg(6, 50000, 168, 192, 193);
        step(8'h40, 200, 195, 1);
        step(8'h40, 200, 195, 0);
        idle(2);
        chk("same_cycle_old", 32'(MEM_ADDR), 20344);
        step(8'h00, 2047, 2047, 1);
        step(8'h40, 200, 195, 0);
        idle(1);
        chk("next_frame_new", 32'(MEM_ADDR), 50344);
        idle(L + 4);
        step(8'h80, 6, 2, 0);
        step(8'h01, 0, 0, 0);
        idle(L + 2);
`ifdef SPRITE_FETCH_TRANSPARENCY_EN
        chk("key_rgb", 32'(RGB), 24'h00FF00);
        chk("key_sel", 32'(SEL_IDX), 7);
`else
        chk("pass_rgb", 32'(RGB), 24'hFF00FF);
        chk("pass_sel", 32'(SEL_IDX), 0);
`endif
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0)
                set_cfg($urandom_range(7), $urandom_range((1 << AW) - 1), $urandom_range(511),
                        $urandom_range(511), $urandom_range(511));
            step($urandom_range(3) == 0 ? 8'h00 : 8'($urandom),
                 $urandom_range(9) == 0 ? 2047 : $urandom_range(799),
                 $urandom_range(9) == 0 ? 2047 : $urandom_range(599),
                 $urandom_range(49) == 0);
        end
        idle(L + 4);
        step(8'h80, 5, 2, 0);
        idle(2);
        do_reset(1);
        chk_reset_state();
        for (int i = 0; i < L + 3; i++) begin
            step(8'h00, 2047, 2047, 0);
            chk("flush_valid", 32'(RGB_VALID), 0);
        end
        set_cfg(3, 777, 10, 1, 1);
        step(8'h00, 2047, 2047, 0);
        step(8'h00, 2047, 2047, 1);
        for (int i = 0; i < 6; i++) step(8'h18, 10 + i, 4, 0);
        idle(L + 5);
        chk("rd_queue_empty", 32'(aq.size()), 0);
        chk("px_queue_empty", 32'(oq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sprite_fetch_arbiter.md
Name: sprite_fetch_arbiter

Overview:
- Per-pixel arbiter and sequencer for the single-port sprite pixel memory shared by the background and the seven game sprites (blue, green, red, yellow, lose, win, power).
- Takes the per-pixel sprite-enable vector and the X/Y coordinates from the VGA controller and picks one winning sprite per pixel.
- Computes that sprite's memory address from a frame-synchronised configuration table, issues the read, and returns a registered RGB pixel with fixed latency.

Parameters:
- MEM_LAT, 2, read latency of the pixel memory in VGA_CLK cycles (≥1).
- ADDR_W, 19, pixel memory address width.
- KEY_COLOR, 24'hFF00FF, transparency key (used only with the optional feature).

Ports:
- VGA_CLK  in  1  pixel clock
- RESET  in  1  synchronous, active-high reset
- SPRITES_EN  in  8  {BACKGROUND, BLUE, GREEN, RED, YELLOW, LOSE, WIN, PWR}, bit7..bit0
- X  in  11  display x; 11'h7FF when outside the display window
- Y  in  11  display y; 11'h7FF when outside the display window
- FRAME_START  in  1  one-cycle pulse in vertical blank; commits the shadow configuration
- CFG_WE  in  1  shadow table write strobe
- CFG_IDX  in  3  table entry, 0..7 = SPRITES_EN bit index
- CFG_BASE  in  ADDR_W  sprite base address
- CFG_W  in  9  sprite width in pixels
- CFG_X0  in  9  sprite left edge, display coordinates
- CFG_Y0  in  9  sprite top edge, display coordinates
- MEM_RD  out  1  memory read strobe
- MEM_ADDR  out  ADDR_W  memory address
- MEM_DATA  in  24  memory read data, valid MEM_LAT cycles after MEM_RD
- RGB  out  24  output pixel
- RGB_VALID  out  1  RGB holds a fetched pixel
- SEL_IDX  out  3  winning index aligned with RGB, diagnostic

Behaviour:
- Reset: all shadow and active table entries cleared to 0; all pipeline stages invalid. MEM_RD=0, MEM_ADDR=0, RGB=0, RGB_VALID=0, SEL_IDX=0. Reset mid-frame flushes in-flight reads; their data is ignored.
- Priority: lowest set bit of SPRITES_EN wins (PWR highest, BACKGROUND lowest). No bit set → bubble.
- Stage S1 (t+1): register valid, winner index, lx=X[8:0]-X0[idx] and ly=Y[8:0]-Y0[idx], all modulo 512.
- Stage S2 (t+2): MEM_ADDR = BASE + ly*W + lx, truncated to ADDR_W. MEM_RD = S1 valid.
- For a bubble, MEM_RD=0 and MEM_ADDR holds its previous value.
- Data stage (t+2+MEM_LAT): MEM_DATA sampled. Valid, index and transparency information travel through a MEM_LAT-deep shift register alongside the read.
- Output (t+3+MEM_LAT): RGB=MEM_DATA, RGB_VALID=1, SEL_IDX=index.
- Output for a bubble: RGB=0, RGB_VALID=0, SEL_IDX holds.
- Throughput: one pixel per clock. No stalls, no backpressure.
- Total latency is MEM_LAT+3 (5 by default). The upstream counter offset is sized to compensate.
- Configuration: CFG_WE writes all four fields of shadow entry CFG_IDX in one cycle.
- FRAME_START copies all 8 shadow entries to the active table in one cycle.
- CFG_WE and FRAME_START in the same cycle: the write lands in shadow only; the active table takes the pre-write shadow, so the new value becomes active at the next FRAME_START.
- Pixels already in the pipeline use the table they were addressed with.
- Duplicate CFG_WE to the same index: last write wins.
- Configuration never alters the arbitration order.

Optional Feature:
- Macro: SPRITE_FETCH_TRANSPARENCY_EN.
- Defined: when the fetched MEM_DATA equals KEY_COLOR, the output is the registered fallback BG_COLOR (24'h000000 after reset) with RGB_VALID=1. SEL_IDX is forced to 7.
- Defined: every non-key pixel fetched for index 7 updates BG_COLOR.
- Not defined: MEM_DATA is passed unchanged and no key compare is instantiated.

Test Plan:
- Reset, then SPRITES_EN=8'h00 and X=Y=11'h7FF for 20 cycles → MEM_RD=0, RGB=0, RGB_VALID=0 throughout.
- Entry 7 = {BASE=0, W=360, X0=0, Y0=0}, FRAME_START, X=5, Y=2, SPRITES_EN=8'h80 → MEM_ADDR=725 at t+2; memory returns 24'h123456 → RGB=24'h123456, RGB_VALID=1, SEL_IDX=7 at t+5.
- Entry 6 = {BASE=20000, W=168, X0=192, Y0=193}, SPRITES_EN=8'hC0, X=200, Y=195 → index 6 wins, MEM_ADDR=20000+2*168+8=20344.
- SPRITES_EN=8'hC1 with entry 0 configured → SEL_IDX=0. Back-to-back pixels each cycle → one MEM_RD per cycle, RGB stream matches memory data in order.
- CFG_WE to entry 6 with BASE=50000 in the same cycle as FRAME_START → next frame still uses 20000; the frame after uses 50000.
- With SPRITE_FETCH_TRANSPARENCY_EN: background pixel 24'h00FF00 then sprite pixel 24'hFF00FF → second output is 24'h00FF00 with SEL_IDX=7.
- Assert RESET at t+3 of an in-flight fetch → RGB_VALID=0 for the next MEM_LAT+3 cycles.
